// File: rtl/fetch_queue.sv
// Instruction fetch queue: buffers {PC, instruction} pairs from IF and
// presents them in order to ID, freezing IF when full and emptying on flush.
module fetch_queue #(
    parameter int WORD_LEN = 32,
    parameter int DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ifValid,
    input  logic [WORD_LEN-1:0]          ifPC,
    input  logic [WORD_LEN-1:0]          ifInstruction,
    input  logic                         flush,
    input  logic                         idFreeze,
    output logic                         freezeIF,
    output logic                         idValid,
    output logic [WORD_LEN-1:0]          idPC,
    output logic [WORD_LEN-1:0]          idInstruction,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WORD_LEN-1:0] pc_mem_q  [DEPTH];
    logic [WORD_LEN-1:0] ins_mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic full, empty, push, pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    // Push uses the pre-edge full flag, so a simultaneous pop cannot make room.
    assign push  = ifValid & ~full & ~flush;
    assign pop   = ~empty & ~idFreeze & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; stale data is masked by the empty gating below.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]  <= ifPC;
            ins_mem_q[wr_ptr_q] <= ifInstruction;
        end
    end

    assign freezeIF      = full;
    assign idValid       = ~empty;
    assign idPC          = empty ? '0 : pc_mem_q[rd_ptr_q];
    assign idInstruction = empty ? '0 : ins_mem_q[rd_ptr_q];
    assign count         = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_fetch_queue;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ifValid = 1'b0;
    logic [W-1:0]  ifPC = '0;
    logic [W-1:0]  ifInstruction = '0;
    logic          flush = 1'b0;
    logic          idFreeze = 1'b0;
    logic          freezeIF;
    logic          idValid;
    logic [W-1:0]  idPC;
    logic [W-1:0]  idInstruction;
    logic [CW-1:0] count;

    int vectors = 0;
    int errors  = 0;

    logic [2*W-1:0] mq[$];

    fetch_queue #(.WORD_LEN(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .ifValid(ifValid), .ifPC(ifPC),
        .ifInstruction(ifInstruction), .flush(flush), .idFreeze(idFreeze),
        .freezeIF(freezeIF), .idValid(idValid), .idPC(idPC),
        .idInstruction(idInstruction), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ins_of(input logic [W-1:0] pc);
        return pc ^ 32'hC0DE_0000;
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] pc,
                         input logic frz, input logic fl);
        ifValid = v;
        ifPC = pc;
        ifInstruction = ins_of(pc);
        idFreeze = frz;
        flush = fl;
    endtask

    // Reference behaviour of one clock edge, from the queue's rules.
    function automatic void model_edge();
        bit was_full;
        bit was_empty;
        was_full  = (mq.size() == D);
        was_empty = (mq.size() == 0);
        if (flush) begin
            mq.delete();
        end else begin
            if (!was_empty && !idFreeze) void'(mq.pop_front());
            if (ifValid && !was_full) mq.push_back({ifPC, ifInstruction});
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if (count !== 0 || idValid !== 0 || freezeIF !== 0 || idPC !== 0) begin
            errors++;
            $display("FAIL reset_init count=%0d idValid=%b freezeIF=%b idPC=%h expected 0/0/0/0",
                     count, idValid, freezeIF, idPC);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, W'(i * 4), 1'b1, 1'b0);
            step();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        vectors++;
        if (count !== 3) begin
            errors++;
            $display("FAIL reset_prefill count=%0d expected 3", count);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (count !== 0 || idValid !== 0 || freezeIF !== 0) begin
            errors++;
            $display("FAIL reset_async count=%0d idValid=%b freezeIF=%b expected 0/0/0",
                     count, idValid, freezeIF);
        end
        mq.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, W'(i * 4), 1'b1, 1'b0);
            step();
        end
        vectors++;
        if (count !== 4 || freezeIF !== 1) begin
            errors++;
            $display("FAIL fill_full count=%0d freezeIF=%b expected 4/1", count, freezeIF);
        end
        drive(1'b1, 32'h10, 1'b1, 1'b0);
        step();
        vectors++;
        if (count !== 4 || idPC !== 32'h0 || idInstruction !== ins_of(32'h0)) begin
            errors++;
            $display("FAIL fill_refuse count=%0d idPC=%h expected 4/00000000", count, idPC);
        end
    endtask

    task automatic test_push_pop();
        drive(1'b0, '0, 1'b0, 1'b1);
        step();
        drive(1'b1, 32'h4, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'h8, 1'b1, 1'b0);
        step();
        vectors++;
        if (count !== 2 || idPC !== 32'h4) begin
            errors++;
            $display("FAIL pp_setup count=%0d idPC=%h expected 2/00000004", count, idPC);
        end
        drive(1'b1, 32'hC, 1'b0, 1'b0);
        step();
        vectors++;
        if (count !== 2 || idPC !== 32'h8) begin
            errors++;
            $display("FAIL pp_both count=%0d idPC=%h expected 2/00000008", count, idPC);
        end
    endtask

    task automatic test_flush();
        drive(1'b0, '0, 1'b0, 1'b1);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, W'(32'h20 + i * 4), 1'b1, 1'b0);
            step();
        end
        drive(1'b1, 32'h30, 1'b1, 1'b1);
        step();
        vectors++;
        if (count !== 0 || idValid !== 0 || freezeIF !== 0) begin
            errors++;
            $display("FAIL flush_clear count=%0d idValid=%b freezeIF=%b expected 0/0/0",
                     count, idValid, freezeIF);
        end
        drive(1'b1, 32'h40, 1'b1, 1'b0);
        step();
        vectors++;
        if (idValid !== 1 || idPC !== 32'h40 || idInstruction !== ins_of(32'h40) || count !== 1) begin
            errors++;
            $display("FAIL flush_refill idValid=%b idPC=%h count=%0d expected 1/00000040/1",
                     idValid, idPC, count);
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] seen[$];
        drive(1'b0, '0, 1'b0, 1'b1);
        step();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, W'(i * 4), 1'b0, 1'b0);
            if (idValid) seen.push_back(idPC);
            step();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        for (int k = 0; k < 20 && idValid; k++) begin
            seen.push_back(idPC);
            step();
        end
        vectors++;
        if (idValid !== 0 || seen.size() != 10) begin
            errors++;
            $display("FAIL wrap_drain idValid=%b seen=%0d expected 0/10", idValid, seen.size());
        end
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (i >= seen.size()) begin
                errors++;
                $display("FAIL wrap_order[%0d] missing expected %h", i, W'(i * 4));
            end else if (seen[i] !== W'(i * 4)) begin
                errors++;
                $display("FAIL wrap_order[%0d] got %h expected %h", i, seen[i], W'(i * 4));
            end
        end
    endtask

    task automatic test_full_pop();
        drive(1'b0, '0, 1'b0, 1'b1);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, W'(32'h60 + i * 4), 1'b1, 1'b0);
            step();
        end
        drive(1'b1, 32'h70, 1'b0, 1'b0);
        step();
        vectors++;
        if (count !== 3 || freezeIF !== 0 || idPC !== 32'h64) begin
            errors++;
            $display("FAIL fullpop_first count=%0d freezeIF=%b idPC=%h expected 3/0/00000064",
                     count, freezeIF, idPC);
        end
        step();
        vectors++;
        if (count !== 3 || idPC !== 32'h68) begin
            errors++;
            $display("FAIL fullpop_resume count=%0d idPC=%h expected 3/00000068", count, idPC);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] epc;
        logic [W-1:0] eins;
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 15) == 0);
            ifInstruction = $urandom;
            step();
            epc  = (mq.size() != 0) ? mq[0][2*W-1:W] : '0;
            eins = (mq.size() != 0) ? mq[0][W-1:0]   : '0;
            vectors++;
            if (count !== CW'(mq.size()) || idValid !== (mq.size() != 0) ||
                freezeIF !== (mq.size() == D) || idPC !== epc || idInstruction !== eins) begin
                errors++;
                $display("FAIL random[%0d] got cnt=%0d v=%b fz=%b pc=%h ins=%h expected cnt=%0d pc=%h ins=%h",
                         n, count, idValid, freezeIF, idPC, idInstruction, mq.size(), epc, eins);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_push_pop();
        test_flush();
        test_wrap();
        test_full_pop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
